// File: rtl/cmpi_pipe.sv
// Purpose : join lhs/rhs tokens and register a 1-bit integer compare (eq/ne/s*/u*) through an elastic pipe.
// Latency : LATENCY edges from acceptance to result_valid (0 = combinational); one token per cycle sustained.
// Backpr. : ready chain is combinational per stage; pipe holds LATENCY tokens, result held stable while stalled.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset (unused when LATENCY=0)
//   lhs/lhs_valid/lhs_ready     - left operand token
//   rhs/rhs_valid/rhs_ready     - right operand token
//   result/result_valid/result_ready - 1-bit predicate result token
module cmpi_pipe #(
    parameter int DATA_TYPE = 32,
    parameter int PREDICATE = 2,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    input  logic                 result_ready,
    output logic                 result,
    output logic                 result_valid,
    output logic                 lhs_ready,
    output logic                 rhs_ready
);

    // Reject unsupported configurations at elaboration.
    if (PREDICATE < 0 || PREDICATE > 9) begin : g_bad_predicate
        $error("cmpi_pipe: PREDICATE must be 0..9");
    end
    if (LATENCY < 0 || LATENCY > 8) begin : g_bad_latency
        $error("cmpi_pipe: LATENCY must be 0..8");
    end
    if (DATA_TYPE < 1) begin : g_bad_width
        $error("cmpi_pipe: DATA_TYPE must be >= 1");
    end

    logic w_cmp;
    logic w_in_vld;
    logic w_s_ready0;

    always_comb begin
        w_cmp = 1'b0;
        case (PREDICATE)
            0:       w_cmp = (lhs == rhs);
            1:       w_cmp = (lhs != rhs);
            2:       w_cmp = ($signed(lhs) <  $signed(rhs));
            3:       w_cmp = ($signed(lhs) <= $signed(rhs));
            4:       w_cmp = ($signed(lhs) >  $signed(rhs));
            5:       w_cmp = ($signed(lhs) >= $signed(rhs));
            6:       w_cmp = (lhs <  rhs);
            7:       w_cmp = (lhs <= rhs);
            8:       w_cmp = (lhs >  rhs);
            9:       w_cmp = (lhs >= rhs);
            default: w_cmp = 1'b0;
        endcase
    end

    // Join: an operand is only consumed together with its partner.
    assign w_in_vld  = lhs_valid & rhs_valid;
    assign lhs_ready = rhs_valid & w_s_ready0;
    assign rhs_ready = lhs_valid & w_s_ready0;

    if (LATENCY == 0) begin : g_comb
        logic w_unused_rst;
        assign w_unused_rst = rst;
        assign w_s_ready0   = result_ready;
        assign result_valid = w_in_vld;
        assign result       = w_cmp;
    end else begin : g_pipe
        logic [LATENCY-1:0] r_v;
        logic [LATENCY-1:0] r_r;
        logic [LATENCY:0]   w_s_ready;

        // A stage can load when it is empty or its successor can load this cycle.
        always_comb begin
            w_s_ready          = '0;
            w_s_ready[LATENCY] = result_ready;
            for (int k = LATENCY - 1; k >= 0; k--) begin
                w_s_ready[k] = ~r_v[k] | w_s_ready[k+1];
            end
        end

        assign w_s_ready0 = w_s_ready[0];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= '0;
                r_r <= '0;
            end else begin
                if (w_s_ready[0]) begin
                    r_v[0] <= w_in_vld;
                    if (w_in_vld) begin
                        r_r[0] <= w_cmp;
                    end
                end
                for (int k = 1; k < LATENCY; k++) begin
                    if (w_s_ready[k]) begin
                        r_v[k] <= r_v[k-1];
                        // Payload only moves with a token, so a stalled result never changes.
                        if (r_v[k-1]) begin
                            r_r[k] <= r_r[k-1];
                        end
                    end
                end
            end
        end

        assign result_valid = r_v[LATENCY-1];
        assign result       = r_r[LATENCY-1];
    end

endmodule
